// File: rtl/logic_seq_pkg.sv
// logic_seq_pkg: opcodes, FSM states, flag bundle and count-width helper for logic_seq.
package logic_seq_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
  typedef struct packed {
    logic za;
    logic zb;
    logic eq;
    logic gt;
    logic lt;
    logic zr;
    logic err;
  } flags_t;
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_NOR  = 4'h2;
  localparam logic [3:0] OP_NOTA = 4'h4;
  localparam logic [3:0] OP_NOTB = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_SHL  = 4'h8;
  localparam logic [3:0] OP_SHR  = 4'h9;
  localparam logic [3:0] OP_ROL  = 4'hA;
  localparam logic [3:0] OP_ROR  = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_CLZ  = 4'hD;
  function automatic int cw_of(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/logic_seq_bitscan.sv
// logic_seq_bitscan: chunk-serial popcount / leading-zero accumulator, MSB chunk first.
module logic_seq_bitscan
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 8,
  localparam int CW = cw_of(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic            mode_i,
  input  logic [STEP-1:0] chunk_i,
  output logic [CW-1:0]   count_o,
  output logic            found_o
);
  logic [CW-1:0] cnt_q, cnt_d, pc, lz;
  logic found_q, found_d, hit;
  always_comb begin
    pc = '0;
    lz = '0;
    hit = 1'b0;
    for (int i = STEP - 1; i >= 0; i--) begin
      pc = pc + CW'(chunk_i[i]);
      if (!hit && !chunk_i[i]) lz = lz + CW'(1);
      hit = hit | chunk_i[i];
    end
    // leading zeros only count until the first one has been seen
    cnt_d = cnt_q + (mode_i ? (found_q ? '0 : lz) : pc);
    found_d = found_q | hit;
  end
  assign count_o = cnt_d;
  assign found_o = found_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      found_q <= 1'b0;
    end else if (clr_i) begin
      cnt_q <= '0;
      found_q <= 1'b0;
    end else if (en_i) begin
      cnt_q <= cnt_d;
      found_q <= found_d;
    end
  end
endmodule

// File: rtl/logic_seq.sv
// logic_seq: handshaked bitwise/shift/rotate unit with iterative POPCNT and CLZ.
module logic_seq
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP = 8,
  localparam int CW = cw_of(WIDTH),
  localparam int SA = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic             cmp_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outlu,
  output logic             za,
  output logic             zb,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             zr,
  output logic             err
);
  localparam int N = WIDTH / STEP;
  localparam int IW = $clog2(N) + 1;
  state_t state_q, state_d;
  flags_t flags_q, flags_d;
  logic [WIDTH-1:0] opa_q, opa_d, outlu_q, outlu_d, res, fin;
  logic [IW-1:0] it_q, it_d;
  logic mode_q, mode_d, clr, en, iter, illegal, sgt, slt, found;
  logic [SA-1:0] sh;
  logic [CW-1:0] count;
  logic_seq_bitscan #(.WIDTH(WIDTH), .STEP(STEP)) u_scan (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .en_i(en), .mode_i(mode_q),
    .chunk_i(opa_q[WIDTH-1 -: STEP]), .count_o(count), .found_o(found)
  );
  assign sh = b[SA-1:0];
  assign iter = opcode == OP_POP || opcode == OP_CLZ;
  assign illegal = opcode inside {4'h3, 4'hE, 4'hF};
  assign sgt = cmp_signed ? ($signed(a) > $signed(b)) : (a > b);
  assign slt = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);
  assign fin = (mode_q && !found) ? WIDTH'(WIDTH) : WIDTH'(count);
  always_comb begin
    res = '0;
    case (opcode)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_NOR:  res = ~(a | b);
      OP_NOTA: res = ~a;
      OP_NOTB: res = ~b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_SHL:  res = a << sh;
      OP_SHR:  res = a >> sh;
      OP_ROL:  res = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_ROR:  res = (a >> sh) | (a << (WIDTH - int'(sh)));
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    opa_d = opa_q;
    outlu_d = outlu_q;
    it_d = it_q;
    mode_d = mode_q;
    clr = 1'b0;
    en = 1'b0;
    case (state_q)
      S_IDLE: if (in_valid) begin
        flags_d = {a == '0, b == '0, a == b, sgt, slt, !iter && res == '0, illegal};
        opa_d = a;
        it_d = '0;
        mode_d = opcode == OP_CLZ;
        clr = iter;
        outlu_d = iter ? '0 : res;
        state_d = iter ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        en = 1'b1;
        opa_d = opa_q << STEP;
        it_d = it_q + IW'(1);
        if (it_q == IW'(N - 1)) begin
          state_d = S_DONE;
          outlu_d = fin;
          flags_d.zr = fin == '0;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      flags_q <= '0;
      opa_q <= '0;
      outlu_q <= '0;
      it_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      opa_q <= opa_d;
      outlu_q <= outlu_d;
      it_q <= it_d;
      mode_q <= mode_d;
    end
  end
  assign in_ready = state_q == S_IDLE;
  assign out_valid = state_q == S_DONE;
  assign outlu = outlu_q;
  assign {za, zb, eq, gt, lt, zr, err} = flags_q;
endmodule

// File: tb/tb_logic_seq.sv
// tb_logic_seq: random and directed checks of logic_seq against a behavioural model.
module tb_logic_seq;
  localparam int W = 32;
  localparam int STEP = 8;
  localparam int N = W / STEP;
  localparam int SA = $clog2(W);
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cmp_signed = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] opcode = '0;
  logic in_ready, out_valid, za, zb, eq, gt, lt, zr, err;
  logic [W-1:0] outlu;
  logic [6:0] dfl;
  int total = 0, bad = 0;
  bit pend = 0, chk_on = 0;
  int rem = 0;
  logic [W-1:0] e_out;
  logic [6:0] e_fl;
  logic [W-1:0] g_out;
  logic [6:0] g_fl;
  int g_lat;

  logic_seq #(.WIDTH(W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .opcode(opcode), .cmp_signed(cmp_signed), .out_valid(out_valid), .out_ready(out_ready),
    .outlu(outlu), .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt), .zr(zr), .err(err)
  );
  assign dfl = {za, zb, eq, gt, lt, zr, err};
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op,
                       input logic cs, output logic [W-1:0] o, output logic [6:0] f);
    int sh;
    logic [2*W-1:0] d;
    logic e, g, l;
    sh = int'(y[SA-1:0]);
    d = {x, x};
    e = 1'b0;
    o = '0;
    case (op)
      4'h0: o = x & y;
      4'h1: o = x | y;
      4'h2: o = ~(x | y);
      4'h4: o = ~x;
      4'h5: o = ~y;
      4'h6: o = x ^ y;
      4'h7: o = ~(x ^ y);
      4'h8: o = x << sh;
      4'h9: o = x >> sh;
      4'hA: begin d = d << sh; o = d[2*W-1:W]; end
      4'hB: begin d = d >> sh; o = d[W-1:0]; end
      4'hC: o = W'($countones(x));
      4'hD: begin
        o = W'(W);
        for (int i = W - 1; i >= 0; i--) if (x[i]) begin o = W'(W - 1 - i); break; end
      end
      default: e = 1'b1;
    endcase
    g = cs ? ($signed(x) > $signed(y)) : (x > y);
    l = cs ? ($signed(x) < $signed(y)) : (x < y);
    f = {x == '0, y == '0, x == y, g, l, o == '0, e};
  endtask

  // reference: pending transaction with remaining cycles until its result shows
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = 0;
      rem = 0;
    end else if (pend) begin
      if (rem == 0) begin
        if (out_ready) pend = 0;
      end else rem--;
    end else if (in_valid) begin
      pend = 1;
      rem = (opcode == 4'hC || opcode == 4'hD) ? N : 0;
      model(a, b, opcode, cmp_signed, e_out, e_fl);
    end
  end

  always @(negedge clk) if (rst_n && chk_on) begin
    chk("in_ready", in_ready, !pend);
    chk("out_valid", out_valid, pend && rem == 0);
    if (pend && rem == 0) begin
      chk("outlu", outlu, e_out);
      chk("flags", dfl, e_fl);
    end
  end

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] op,
                     input logic cs, input int hold);
    @(negedge clk);
    in_valid = 1'b1; a = x; b = y; opcode = op; cmp_signed = cs;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; opcode = 4'($urandom); cmp_signed = 1'($urandom);
    g_lat = 0;
    do begin
      @(negedge clk);
      g_lat++;
    end while (!out_valid && g_lat < 50);
    if (!out_valid) begin
      chk("timeout", 1, 0);
      return;
    end
    g_out = outlu;
    g_fl = dfl;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] x, y;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outlu", outlu, 0);
    chk("rst_flags", dfl, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1;
    run(32'hF0F000FF, 32'h0FF00F0F, 4'h0, 0, 0);
    chk("and_out", g_out, 32'h00F0000F);
    chk("and_lat", g_lat, 1);
    chk("and_eq_gt_lt_err", {g_fl[4:2], g_fl[0]}, 4'b0100);
    run(32'hFFFF0001, 0, 4'hC, 0, 0);
    chk("pop_out", g_out, 17);
    chk("pop_lat", g_lat, 5);
    run(32'h00010000, 0, 4'hD, 0, 0);
    chk("clz_out", g_out, 15);
    run(32'h0, 5, 4'hD, 0, 1);
    chk("clz0_out", g_out, 32);
    chk("clz0_za", g_fl[6], 1);
    run(32'h1, 1, 4'hB, 0, 0);
    chk("ror_out", g_out, 32'h80000000);
    run(32'h1234ABCD, 32, 4'hA, 0, 0);
    chk("rol0_out", g_out, 32'h1234ABCD);
    run(32'h80000001, 31, 4'h9, 0, 0);
    chk("shr31_out", g_out, 1);
    run(32'hFFFFFFFF, 1, 4'h0, 1, 0);
    chk("sgn_gt_lt", g_fl[3:2], 2'b01);
    run(32'hFFFFFFFF, 1, 4'h0, 0, 0);
    chk("uns_gt_lt", g_fl[3:2], 2'b10);
    run(32'hFFFFFFFF, 1, 4'hF, 0, 3);
    chk("ill_out", g_out, 0);
    chk("ill_err_zr", {g_fl[0], g_fl[1]}, 2'b11);
    run(32'h0000FFFF, 32'h0000FFFF, 4'h7, 0, 0);
    chk("xnor_out", g_out, 32'hFFFFFFFF);
    chk("xnor_eq", g_fl[4], 1);
    // abort a POPCNT in its second busy cycle
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFFFFFF; opcode = 4'hC;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_outlu", outlu, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run(32'h12345678, 32'hFFFF0000, 4'h6, 0, 0);
    chk("post_rst_xor", g_out, 32'hEDCB5678);
    for (int t = 0; t < 250; t++) begin
      case ($urandom_range(0, 3))
        0: x = '0;
        1: x = '1;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 4) == 0) ? x : $urandom;
      run(x, y, 4'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
